// File: rtl/control_pkg.sv
// Shared state, fault and select encodings for the RV32I multicycle
// control sequencer.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    HALTED,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'b00,
    F_ILLEGAL = 2'b01,
    F_TIMEOUT = 2'b10,
    F_EBREAK  = 2'b11
  } fault_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] RD_ALU = 2'b00;
  localparam logic [1:0] RD_MEM = 2'b01;
  localparam logic [1:0] RD_CSR = 2'b10;
  localparam logic [1:0] RD_PC4 = 2'b11;

  localparam logic [1:0] A1_RS1  = 2'b00;
  localparam logic [1:0] A1_PC   = 2'b01;
  localparam logic [1:0] A1_ZERO = 2'b10;

  localparam logic [1:0] A2_RS2   = 2'b00;
  localparam logic [1:0] A2_IMM   = 2'b01;
  localparam logic [1:0] A2_SHAMT = 2'b10;

  typedef struct packed {
    logic       pc_ne;
    logic       pc_ex;
    logic       pc;
    logic       ir;
    logic       rd;
    logic       csr;
    logic       mrd;
    logic       mwr;
    logic       addr_sel;
    logic [1:0] rd_sel;
    logic [1:0] alu1;
    logic [1:0] alu2;
    logic       retired;
  } ctrl_t;

endpackage

// File: rtl/ctrl_watchdog.sv
// Memory-access watchdog: flags a request left unacknowledged for
// MEM_TIMEOUT consecutive cycles. MEM_TIMEOUT = 0 disables it.
module ctrl_watchdog #(
  parameter int CNT_W       = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // An ack in the terminal cycle beats the timeout.
  assign expired = (MEM_TIMEOUT != 0) && active && !ack
                && (r_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!active || ack || expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle RV32I control FSM: FETCH/EXEC/MEM with debug halt,
// memory watchdog and fault reporting.
module control_sequencer
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit DEBUG_EN    = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_complete,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       halt_req,
  input  logic       resume_req,
  output logic       write_pc_ne,
  output logic       write_pc_ex,
  output logic       write_pc,
  output logic       write_ir,
  output logic       write_rd,
  output logic       write_csr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic [1:0] rd_sel,
  output logic [1:0] alu_insel1,
  output logic [1:0] alu_insel2,
  output logic       retired,
  output logic       halted,
  output logic [1:0] fault_cause
);

  state_t r_state;
  fault_t r_fault;
  ctrl_t  w_c;
  ctrl_t  w_q;
  state_t w_after;
  logic   w_active;
  logic   w_expired;
  logic   w_load;

  assign w_active = (r_state == FETCH) || (r_state == MEM);
  assign w_load   = (opcode == OPC_LOAD);
  assign w_after  = (halt_req && DEBUG_EN) ? HALTED : FETCH;

  ctrl_watchdog #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (w_active),
    .ack    (mem_complete),
    .expired(w_expired)
  );

  always_comb begin
    w_c = '0;
    case (r_state)
      FETCH: begin
        w_c.mrd      = 1'b1;
        w_c.addr_sel = 1'b1;
        w_c.ir       = mem_complete;
      end
      EXEC: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM: begin
            w_c.rd      = 1'b1;
            w_c.pc_ne   = 1'b1;
            w_c.retired = 1'b1;
            if (opcode == OPC_OP)        w_c.alu2 = A2_RS2;
            else if (f3[1:0] == 2'b01)   w_c.alu2 = A2_SHAMT;
            else                         w_c.alu2 = A2_IMM;
          end
          OPC_LUI, OPC_AUIPC: begin
            w_c.rd      = 1'b1;
            w_c.pc_ne   = 1'b1;
            w_c.retired = 1'b1;
            w_c.alu1    = (opcode == OPC_LUI) ? A1_ZERO : A1_PC;
            w_c.alu2    = A2_IMM;
          end
          OPC_JAL, OPC_JALR: begin
            w_c.pc      = 1'b1;
            w_c.rd      = 1'b1;
            w_c.rd_sel  = RD_PC4;
            w_c.retired = 1'b1;
            w_c.alu1    = (opcode == OPC_JAL) ? A1_PC : A1_RS1;
            w_c.alu2    = A2_IMM;
          end
          OPC_BRANCH: begin
            w_c.pc_ex   = 1'b1;
            w_c.retired = 1'b1;
            w_c.alu1    = A1_PC;
            w_c.alu2    = A2_IMM;
          end
          OPC_MISC_MEM: begin
            w_c.pc_ne   = 1'b1;
            w_c.retired = 1'b1;
          end
          OPC_SYSTEM: begin
            if (f3 != 3'b000) begin
              w_c.csr     = 1'b1;
              w_c.rd      = 1'b1;
              w_c.rd_sel  = RD_CSR;
              w_c.pc_ne   = 1'b1;
              w_c.retired = 1'b1;
              w_c.alu1    = f3[2] ? A1_ZERO : A1_RS1;
              w_c.alu2    = A2_IMM;
            end
          end
          default: ;
        endcase
      end
      MEM: begin
        w_c.mrd  = w_load;
        w_c.mwr  = !w_load;
        w_c.alu1 = A1_RS1;
        w_c.alu2 = A2_IMM;
        if (mem_complete) begin
          w_c.pc_ne   = 1'b1;
          w_c.retired = 1'b1;
          w_c.rd      = w_load;
          w_c.rd_sel  = w_load ? RD_MEM : RD_ALU;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_fault <= F_NONE;
    end else begin
      case (r_state)
        FETCH: begin
          if (mem_complete) begin
            r_state <= EXEC;
          end else if (w_expired) begin
            r_state <= FAULT;
            r_fault <= F_TIMEOUT;
          end
        end
        EXEC: begin
          if (w_c.retired) begin
            r_state <= w_after;
          end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
            r_state <= MEM;
          end else if (opcode == OPC_SYSTEM && DEBUG_EN) begin
            r_state <= HALTED;
          end else if (opcode == OPC_SYSTEM) begin
            r_state <= FAULT;
            r_fault <= F_EBREAK;
          end else begin
            r_state <= FAULT;
            r_fault <= F_ILLEGAL;
          end
        end
        MEM: begin
          if (mem_complete) begin
            r_state <= w_after;
          end else if (w_expired) begin
            r_state <= FAULT;
            r_fault <= F_TIMEOUT;
          end
        end
        HALTED: begin
          if (resume_req && !halt_req) r_state <= FETCH;
        end
        FAULT: begin
          if (resume_req) begin
            r_state <= FETCH;
            r_fault <= F_NONE;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Reset is also folded in combinationally so requests drop at once.
  assign w_q = rst ? '0 : w_c;

  assign write_pc_ne = w_q.pc_ne;
  assign write_pc_ex = w_q.pc_ex;
  assign write_pc    = w_q.pc;
  assign write_ir    = w_q.ir;
  assign write_rd    = w_q.rd;
  assign write_csr   = w_q.csr;
  assign mem_read    = w_q.mrd;
  assign mem_write   = w_q.mwr;
  assign addr_sel    = w_q.addr_sel;
  assign rd_sel      = w_q.rd_sel;
  assign alu_insel1  = w_q.alu1;
  assign alu_insel2  = w_q.alu2;
  assign retired     = w_q.retired;
  assign halted      = (r_state == HALTED) || (r_state == FAULT);
  assign fault_cause = r_fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control
// vectors are queued by the stimulus and checked by a monitor.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_complete = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic       halt_req = 1'b0;
  logic       resume_req = 1'b0;

  logic       pcne1, pcex1, pc1, ir1, rd1, csr1, mr1, mw1, as1;
  logic [1:0] rs1, a11, a21, fc1;
  logic       ret1, hlt1;
  logic       pcne2, pcex2, pc2, ir2, rd2, csr2, mr2, mw2, as2;
  logic [1:0] rs2, a12, a22, fc2;
  logic       ret2, hlt2;

  always #5 clk = ~clk;

  control_sequencer #(
    .MEM_TIMEOUT(4), .DEBUG_EN(1'b1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .mem_complete(mem_complete),
    .opcode(opcode), .f3(f3), .halt_req(halt_req),
    .resume_req(resume_req),
    .write_pc_ne(pcne1), .write_pc_ex(pcex1), .write_pc(pc1),
    .write_ir(ir1), .write_rd(rd1), .write_csr(csr1),
    .mem_read(mr1), .mem_write(mw1), .addr_sel(as1),
    .rd_sel(rs1), .alu_insel1(a11), .alu_insel2(a21),
    .retired(ret1), .halted(hlt1), .fault_cause(fc1)
  );

  control_sequencer #(
    .MEM_TIMEOUT(16), .DEBUG_EN(1'b0), .CNT_W(8)
  ) dut2 (
    .clk(clk), .rst(rst), .mem_complete(mem_complete),
    .opcode(opcode), .f3(f3), .halt_req(halt_req),
    .resume_req(resume_req),
    .write_pc_ne(pcne2), .write_pc_ex(pcex2), .write_pc(pc2),
    .write_ir(ir2), .write_rd(rd2), .write_csr(csr2),
    .mem_read(mr2), .mem_write(mw2), .addr_sel(as2),
    .rd_sel(rs2), .alu_insel1(a12), .alu_insel2(a22),
    .retired(ret2), .halted(hlt2), .fault_cause(fc2)
  );

  // {pcne,pcex,pc,ir,rd,csr,mr,mw}, addr_sel, rd_sel, alu1, alu2,
  // retired, halted, fault_cause
  function automatic logic [18:0] mk(
    input logic [7:0] s, input logic as,
    input logic [1:0] rs, input logic [1:0] a1,
    input logic [1:0] a2, input logic ret,
    input logic hlt, input logic [1:0] fc);
    return {s, as, rs, a1, a2, ret, hlt, fc};
  endfunction

  localparam logic [18:0] DC_AS  = 19'h00400;
  localparam logic [18:0] DC_RS  = 19'h00300;
  localparam logic [18:0] DC_A   = 19'h000F0;
  localparam logic [18:0] DC_FS  = DC_RS | DC_A;
  localparam logic [18:0] DC_SEL = DC_AS | DC_RS | DC_A;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] BAD    = 7'b1111111;

  localparam logic [18:0] F0 = mk(8'b00000010, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] F1 = mk(8'b00010010, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] EN = mk(8'b00000000, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [18:0] ADDI =
    mk(8'b10001000, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0);
  localparam logic [18:0] SLLI =
    mk(8'b10001000, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0);
  localparam logic [18:0] LW_W =
    mk(8'b00000010, 0, 2'b00, 2'b00, 2'b01, 0, 0, 0);
  localparam logic [18:0] LW_A =
    mk(8'b10001010, 0, 2'b01, 2'b00, 2'b01, 1, 0, 0);
  localparam logic [18:0] SW_A =
    mk(8'b10000001, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0);
  localparam logic [18:0] JAL_E =
    mk(8'b00101000, 0, 2'b11, 2'b01, 2'b01, 1, 0, 0);
  localparam logic [18:0] JALR_E =
    mk(8'b00101000, 0, 2'b11, 2'b00, 2'b01, 1, 0, 0);
  localparam logic [18:0] BR_E =
    mk(8'b01000000, 0, 2'b00, 2'b01, 2'b01, 1, 0, 0);
  localparam logic [18:0] LUI_E =
    mk(8'b10001000, 0, 2'b00, 2'b10, 2'b01, 1, 0, 0);
  localparam logic [18:0] AUIPC_E =
    mk(8'b10001000, 0, 2'b00, 2'b01, 2'b01, 1, 0, 0);
  localparam logic [18:0] CSRRS_E =
    mk(8'b10001100, 0, 2'b10, 2'b00, 2'b01, 1, 0, 0);
  localparam logic [18:0] CSRRWI_E =
    mk(8'b10001100, 0, 2'b10, 2'b10, 2'b01, 1, 0, 0);

  function automatic logic [18:0] q(input logic h,
                                    input logic [1:0] fc);
    return mk(8'b00000000, 0, 0, 0, 0, 0, h, fc);
  endfunction

  typedef struct {
    string       nm;
    logic [18:0] exp;
    logic [18:0] dc;
    bit          d2;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [18:0] v1, v2;
  assign v1 = {pcne1, pcex1, pc1, ir1, rd1, csr1, mr1, mw1, as1,
               rs1, a11, a21, ret1, hlt1, fc1};
  assign v2 = {pcne2, pcex2, pc2, ir2, rd2, csr2, mr2, mw2, as2,
               rs2, a12, a22, ret2, hlt2, fc2};

  always @(negedge clk) begin
    exp_t        t;
    logic [18:0] a;
    if (sb.size() > 0) begin
      t = sb.pop_front();
      a = t.d2 ? v2 : v1;
      n_vec++;
      if (((a ^ t.exp) & ~t.dc) != 19'd0) begin
        n_err++;
        $display("FAIL %s: got %b required %b (ignore %b)",
                 t.nm, a, t.exp, t.dc);
      end
    end
  end

  task automatic step(input string nm, input logic [18:0] e,
                      input logic [18:0] dc, input bit d2 = 1'b0);
    exp_t t;
    t.nm = nm;
    t.exp = e;
    t.dc = dc;
    t.d2 = d2;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string nm, input logic [6:0] op,
                       input logic [2:0] fn, input int waits);
    opcode = op;
    f3 = fn;
    mem_complete = 1'b0;
    for (int i = 0; i < waits; i++) step({nm, "_fwait"}, F0, DC_FS);
    mem_complete = 1'b1;
    step({nm, "_fetch_ir"}, F1, DC_FS);
    mem_complete = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step("reset", EN, 19'd0);
    rst = 1'b0;

    fetch("addi", OPIMM, 3'b000, 2);
    step("addi_exec", ADDI, DC_AS);
    fetch("slli", OPIMM, 3'b001, 0);
    step("slli_exec", SLLI, DC_AS);

    fetch("lw", LOAD, 3'b010, 1);
    step("lw_exec", EN, DC_SEL);
    step("lw_mem_wait", LW_W, DC_RS);
    mem_complete = 1'b1;
    step("lw_mem_ack", LW_A, 19'd0);
    mem_complete = 1'b0;
    fetch("sw", STORE, 3'b010, 0);
    step("sw_exec", EN, DC_SEL);
    mem_complete = 1'b1;
    step("sw_mem_ack", SW_A, DC_RS);
    mem_complete = 1'b0;

    fetch("jal", JAL, 3'b000, 0);
    step("jal_exec", JAL_E, DC_AS);
    fetch("jalr", JALR, 3'b000, 0);
    step("jalr_exec", JALR_E, DC_AS);
    fetch("beq", BRANCH, 3'b000, 0);
    step("branch_exec", BR_E, DC_AS | DC_RS);
    fetch("lui", LUI, 3'b000, 0);
    step("lui_exec", LUI_E, DC_AS);
    fetch("auipc", AUIPC, 3'b000, 0);
    step("auipc_exec", AUIPC_E, DC_AS);
    fetch("csrrs", SYSTEM, 3'b010, 0);
    step("csrrs_exec", CSRRS_E, DC_AS);
    fetch("csrrwi", SYSTEM, 3'b101, 0);
    step("csrrwi_exec", CSRRWI_E, DC_AS);

    fetch("ack_wins", OPIMM, 3'b000, 3);
    step("ack_wins_exec", ADDI, DC_AS);

    for (int i = 0; i < 4; i++) step("tmo_fetch", F0, DC_FS);
    step("tmo_fault", q(1, 2'b10), DC_SEL);
    resume_req = 1'b1;
    step("tmo_resume", q(1, 2'b10), DC_SEL);
    resume_req = 1'b0;
    fetch("post_tmo", OPIMM, 3'b000, 1);
    step("post_tmo_exec", ADDI, DC_AS);

    halt_req = 1'b1;
    fetch("halt_lw", LOAD, 3'b010, 0);
    step("halt_lw_exec", EN, DC_SEL);
    step("halt_lw_wait", LW_W, DC_RS);
    mem_complete = 1'b1;
    step("halt_lw_ack", LW_A, 19'd0);
    mem_complete = 1'b0;
    step("halted", q(1, 2'b00), DC_SEL);
    resume_req = 1'b1;
    step("halt_and_resume", q(1, 2'b00), DC_SEL);
    halt_req = 1'b0;
    step("resume_edge", q(1, 2'b00), DC_SEL);
    resume_req = 1'b0;
    fetch("post_halt", OPIMM, 3'b000, 1);
    step("post_halt_exec", ADDI, DC_AS);

    fetch("illegal", BAD, 3'b000, 0);
    step("illegal_exec", EN, DC_SEL);
    step("illegal_fault", q(1, 2'b01), DC_SEL);
    resume_req = 1'b1;
    step("illegal_resume", q(1, 2'b01), DC_SEL);
    resume_req = 1'b0;
    fetch("ebreak", SYSTEM, 3'b000, 0);
    step("ebreak_exec", EN, DC_SEL);
    step("ebreak_halted", q(1, 2'b00), DC_SEL);
    resume_req = 1'b1;
    step("ebreak_resume", q(1, 2'b00), DC_SEL);
    resume_req = 1'b0;
    step("pre_rst_fetch", F0, DC_FS);
    rst = 1'b1;
    step("rst_mid_fetch", EN, 19'd0);
    rst = 1'b0;

    fetch("ebreak_nodbg", SYSTEM, 3'b000, 0);
    step("ebreak_nodbg_exec", EN, DC_SEL, 1'b1);
    step("ebreak_nodbg_fault", q(1, 2'b11), DC_SEL, 1'b1);
    resume_req = 1'b1;
    step("ebreak_nodbg_resume", q(1, 2'b11), DC_SEL, 1'b1);
    resume_req = 1'b0;
    halt_req = 1'b1;
    fetch("nodbg_halt", OPIMM, 3'b000, 0);
    step("nodbg_halt_exec", ADDI, DC_AS, 1'b1);
    step("nodbg_halt_ignored", F0, DC_FS, 1'b1);
    halt_req = 1'b0;

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
